// File: rtl/excess3_serial_tx_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// excess3_serial_tx_if : BCD word handshake into the excess-3 serial transmitter
// Revision 1.0
// ---------------------------------------------------------------------------
interface excess3_serial_tx_if #(
  parameter int DIGITS = 2
) ();
  logic [4*DIGITS-1:0] din;
  logic                din_valid;
  logic                din_ready;

  modport master (output din, output din_valid, input  din_ready);
  modport slave  (input  din, input  din_valid, output din_ready);
endinterface
`default_nettype wire

// File: rtl/excess3_serial_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// excess3_serial_tx : BCD word -> excess-3 codes, shifted out LSB first
// Revision 1.0
// ---------------------------------------------------------------------------
module excess3_serial_tx #(
  parameter int DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  excess3_serial_tx_if.slave      in_if,
  output logic                    x,
  output logic                    frame,
  output logic                    last,
  output logic                    busy,
  output logic                    err
);

  localparam int             WIDTH = 4 * DIGITS;
  localparam int             CW    = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST  = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  sr_q, sr_d;
  logic              frame_q, frame_d;
  logic              last_q, last_d;
  logic              err_q, err_d;
  logic              accept;
  logic              din_ready;

  logic [WIDTH-1:0]  codes;
  logic [DIGITS-1:0] bad;

  // Out-of-range digits transmit as 0000 and flag the whole word.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [3:0] d;
    assign d                = in_if.din[4*i +: 4];
    assign bad[i]           = (d > 4'd9);
    assign codes[4*i +: 4]  = bad[i] ? 4'd0 : (d + 4'd3);
  end

  assign din_ready       = (state_q == IDLE) || last_q;
  assign in_if.din_ready = din_ready;

  always_comb begin
    accept  = in_if.din_valid && din_ready;
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    err_d   = 1'b0;
    if (accept) begin
      state_d = SHIFT;
      cnt_d   = '0;
      sr_d    = codes;
      err_d   = |bad;
    end else if (state_q == SHIFT) begin
      if (last_q) begin
        state_d = IDLE;
        cnt_d   = '0;
        sr_d    = '0;
      end else begin
        cnt_d   = cnt_q + CW'(1);
        sr_d    = sr_q >> 1;
      end
    end
    // Strobes are decoded from next-state values so they leave flops.
    frame_d = (state_d == SHIFT) && (cnt_d[1:0] == 2'b00);
    last_d  = (state_d == SHIFT) && (cnt_d == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      frame_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      frame_q <= frame_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign x     = sr_q[0];
  assign frame = frame_q;
  assign last  = last_q;
  assign busy  = (state_q == SHIFT);
  assign err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_excess3_serial_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_excess3_serial_tx : scoreboard bench for excess3_serial_tx (DIGITS=2)
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_excess3_serial_tx;

  localparam int DIGITS = 2;
  localparam int NBITS  = 4 * DIGITS;

  logic clk;
  logic rst_n;
  logic x, frame, last, busy, err;

  excess3_serial_tx_if #(.DIGITS(DIGITS)) bus ();

  excess3_serial_tx #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in_if (bus.slave),
    .x     (x),
    .frame (frame),
    .last  (last),
    .busy  (busy),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected per-cycle vector {x, frame, last, busy, err, din_ready}
  logic [5:0] sq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference: excess-3 per digit, serialised LSB first, digit 0 first.
  task automatic model_push(input logic [NBITS-1:0] w);
    int  codes[DIGITS];
    bit  any_bad = 0;
    for (int i = 0; i < DIGITS; i++) begin
      int d = (int'(w) >> (4 * i)) & 15;
      if (d > 9) begin
        codes[i] = 0;
        any_bad  = 1;
      end else begin
        codes[i] = d + 3;
      end
    end
    for (int j = 0; j < NBITS; j++) begin
      logic b, f, l, e, r;
      b = 1'((codes[j / 4] >> (j % 4)) & 1);
      f = (j % 4 == 0);
      l = (j == NBITS - 1);
      e = any_bad && (j == 0);
      r = l;
      sq.push_back({b, f, l, 1'b1, e, r});
    end
  endtask

  // Called just after a falling edge; returns just after the falling edge
  // following the accepting rising edge.
  task automatic send(input logic [NBITS-1:0] w);
    int t = 0;
    while (!bus.din_ready) begin
      bus.din       = NBITS'($urandom);
      bus.din_valid = 1'($urandom);
      @(negedge clk);
      t++;
      if (t > 200) begin
        chk("ready_timeout", 0, 1);
        bus.din_valid = 1'b0;
        return;
      end
    end
    bus.din       = w;
    bus.din_valid = 1'b1;
    model_push(w);
    @(negedge clk);
    bus.din       = NBITS'($urandom);
    bus.din_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    bus.din_valid = 1'b0;
    while (sq.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sq.size() != 0) chk("drain_timeout", 32'(sq.size()), 0);
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [NBITS-1:0] rand_word();
    logic [NBITS-1:0] w;
    for (int i = 0; i < DIGITS; i++)
      w[4*i +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                 : 4'($urandom_range(0, 9));
    return w;
  endfunction

  // Monitor: every cycle either pops the next expected bit or expects idle.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rst_n) begin
        if (sq.size() != 0)
          chk("bit", {x, frame, last, busy, err, bus.din_ready}, sq.pop_front());
        else
          chk("idle", {x, frame, last, busy, err, bus.din_ready}, 6'b000001);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    bus.din       = '0;
    bus.din_valid = 1'b0;
    #1;
    chk("reset", {x, frame, last, busy, err, bus.din_ready}, 6'b000001);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    send(8'h27); drain();
    send(8'h90); drain();
    send(8'h0C); drain();
    send(8'h27); send(8'h90); drain();

    // Reset in the middle of a word, during bit 3.
    send(8'h27);
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid", {x, frame, last, busy, err, bus.din_ready}, 6'b000001);
    sq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h11); drain();

    for (int n = 0; n < 300; n++) begin
      send(rand_word());
      if ($urandom_range(0, 3) == 0) begin
        bus.din_valid = 1'b0;
        repeat ($urandom_range(1, 12)) @(negedge clk);
      end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/excess3_serial_tx.md
# excess3_serial_tx

Serial transmitter for the excess-3 bit stream consumed by the team's serial excess-3 receiver (`x` input, `clk` domain). It accepts a packed BCD word over a valid/ready handshake and converts each digit to excess-3 (digit + 3). It then shifts the codes out one bit per clock, LSB first, least-significant digit first. Framing strobes mark digit and word boundaries so the receiver side and benches can align.

## Interface
- `DIGITS`, default 2: number of BCD digits per word (1..8).
- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `din` input 4*DIGITS: packed BCD word; digit i = `din[4i+3:4i]`.
- `din_valid` input 1: `din` holds a word to send.
- `din_ready` output 1: transmitter can accept a word this cycle.
- `x` output 1: serial excess-3 data, registered.
- `frame` output 1: high during bit 0 of every digit.
- `last` output 1: high during the final bit of the word.
- `busy` output 1: high while a word is being shifted.
- `err` output 1: one-cycle pulse when an accepted word contains a non-BCD digit (>9).

## Operation
- **FSM states:**
  - IDLE: no word in flight.
  - SHIFT: shifting the current word.
- **Accept:** a word is accepted on a rising edge where `din_valid && din_ready`.
- **`din_ready`:**
  - 1 in IDLE.
  - 1 in SHIFT only during the final bit cycle (`last`=1), for back-to-back words.
  - 0 otherwise.
- **Conversion at accept:** each digit d is converted to 4 bits:
  - d ≤ 9: code = d + 3, 4-bit result with no carry possible (max 12).
  - d ≥ 10: code = 4'b0000, and `err` pulses for one cycle on the first bit cycle of that word. There is one pulse per word regardless of how many digits are bad.
- **Shift register:** width 4*DIGITS, loaded with the concatenated codes (digit 0 in the low nibble) and shifted right one bit per clock; `x` = register bit 0.
- **Bit counter:** counts 0..4*DIGITS-1. The bit index within a digit is `cnt[1:0]`.
  - `frame` = (`cnt[1:0]`==0) in SHIFT.
  - `last` = (`cnt`==4*DIGITS-1) in SHIFT.
- **Transitions:**
  - IDLE → SHIFT on accept.
  - SHIFT → SHIFT on accept during the last bit: the counter reloads to 0 and the new word is loaded.
  - SHIFT → IDLE after the last bit if no accept.
- **IDLE outputs:** `x`=0, `frame`=0, `last`=0, `busy`=0.
- **Handshake rules:** `din` is sampled only at accept. Changes to `din`/`din_valid` while `din_ready`=0 are ignored.

## Timing
- **Reset values:** asynchronous `rst_n`=0 forces IDLE, counter 0, shift register 0, `x`=0, `frame`=0, `last`=0, `busy`=0, `err`=0, `din_ready`=1, immediately and without waiting for a clock edge.
- **Latency:** accept at edge k places bit 0 of digit 0 on `x` in the cycle after edge k. `frame`=1 and `busy`=1 in that same cycle.
- **Word length:** a word occupies exactly 4*DIGITS consecutive cycles. Bit j of the word is on `x` in cycle k+1+j.
- **Back-to-back:** an accept in the `last` cycle yields bit 0 of the next word in the following cycle, with zero idle gap and `busy` held high.
- **Reset mid-word:** output drops to IDLE values at once, and the partial word is discarded, not resumed. The first accept after `rst_n` deasserts behaves as from power-up.
- **`err` timing:** asserted in cycle k+1 only, coincident with the first `frame`.
- **DIGITS=1:** `frame` and `last` are both high on bit 0 and bit 3 respectively. The counter wraps at 3.

## Test plan
- **Basic word:** DIGITS=2, `din`=8'h27 accepted once → `x` over 8 cycles = 0,1,0,1,1,0,1,0; `frame` high on cycles 1 and 5; `last` on cycle 8; `busy` high for 8 cycles; `err`=0; then IDLE with `x`=0.
- **Boundary digits:** `din`=8'h90 → `x` = 1,1,0,0,0,0,1,1 (0→0011, 9→1100), `err`=0.
- **Invalid digit:** `din`=8'h0C → `x` = 0,0,0,0,1,1,0,0; `err` high exactly in cycle 1; `busy`=1 for 8 cycles.
- **Back-to-back:** `din_valid` held high with 8'h27 then 8'h90 (switched on the cycle after the first accept) → 16 contiguous bits with no gap. `din_ready` is high only on the 8th bit, and `frame` is high on cycles 1, 5, 9 and 13.
- **Stall ignored:** `din` changes while `busy` and `din_ready`=0 → the transmitted bits are unaffected.
- **Reset mid-word:** assert `rst_n`=0 at bit 3 of 8'h27 → `x`, `busy`, `frame` go 0 without a clock edge. After release, accepting 8'h11 sends 0,0,1,0,0,0,1,0 cleanly.
